bias_ram_loader: RTL and testbench
==================================

Name: bias_ram_loader

Overview:
- Upstream stage of the bias RAM. It accepts a stream of packed bias words from the AXI DMA side and turns them into the bias RAM's write-port signals: write data, write address and write enable.
- It loads a programmed number of AXI_WIDTH words, starting at address 0.
- It zero-pads the tail so the last read row (4 write words per read row) is fully defined.
- It then pulses done to the layer controller.

Parameters:
- ADDR_BITS, 9, bias RAM write-port address width; read port uses ADDR_BITS-2, i.e. 4 write words per read row.
- DATA_W, `AXI_WIDTH_DATA (64), width of one stream/write word.

Ports:
- clk  in  1  clock, single domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- word_num  in  ADDR_BITS+1  number of DATA_W words to load; latched on accepted start
- s_tdata  in  DATA_W  stream data
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- ram_wdata  out  DATA_W  to bias RAM input_data
- ram_waddr  out  ADDR_BITS  to bias RAM write_address
- ram_we  out  1  to bias RAM write_enable
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when load and padding complete

Behaviour:
- Reset values: s_tready=0, ram_wdata=0, ram_waddr=0, ram_we=0, busy=0, done=0; FSM=IDLE; counters=0.
- State IDLE:
  - start=1: latch N=min(word_num, 2^ADDR_BITS), clear address counter, busy=1.
  - If N=0, go to DONE; otherwise go to LOAD.
- State LOAD:
  - s_tready=1 for the whole state; it is a registered output, asserted the cycle after entry.
  - Handshake: s_tvalid&&s_tready. On each handshake the next cycle has ram_we=1, ram_wdata=s_tdata, ram_waddr=addr, and addr increments.
  - Write latency from handshake to write is exactly 1 cycle.
  - No handshake means ram_we=0 that cycle; ram_wdata/ram_waddr hold.
  - Gaps in s_tvalid are tolerated; no timeout.
  - On the N-th handshake, s_tready drops the following cycle, so no extra word is accepted.
  - Next state is PAD if N mod 4 != 0, else DONE.
- State PAD:
  - s_tready=0.
  - Writes zero words on consecutive cycles (ram_we=1, ram_wdata=0) at addr until addr mod 4 == 0, then goes to DONE.
  - Exception: if N=2^ADDR_BITS, addr wraps to 0, no padding is needed and PAD is skipped.
- State DONE:
  - done=1 for one cycle, busy=0 the same cycle, ram_we=0.
  - Next state IDLE.
- start while busy: ignored, with no effect on the latched N.
- start in the DONE cycle: ignored. A new start is accepted from IDLE only, so back-to-back loads need at least 1 idle cycle.
- Address counter is ADDR_BITS+1 wide internally; ram_waddr is its low ADDR_BITS bits.
- word_num > 2^ADDR_BITS: clipped to 2^ADDR_BITS.
- Reset mid-load:
  - Immediate return to IDLE with all outputs at reset values.
  - RAM contents are left as partially written.
  - Words still pending on the stream are not consumed.

Optional Feature:
- Macro: BIAS_LOAD_CHECKSUM_EN.
- With the macro defined:
  - Extra output port checksum (DATA_W, out).
  - It is the XOR of every accepted s_tdata word of the current load; padding words contribute 0.
  - Cleared on accepted start; valid and stable from the done pulse until the next accepted start.
  - Reset value 0.
- Without the macro: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include (Para.v) holds:
  - AXI_WIDTH_DATA and Channel_Out_Num (already present);
  - WORDS_PER_ROW = (Channel_Out_Num*32)/AXI_WIDTH_DATA = 4;
  - FSM state encodings IDLE=2'd0, LOAD=2'd1, PAD=2'd2, DONE=2'd3.
- No sub-module needed; a single FSM plus counter. The checksum register is inline logic under the macro.

Test Plan:
- word_num=8, s_tvalid held high, data 0x1..0x8:
  - 8 writes at addr 0..7 on consecutive cycles, each 1 cycle after its handshake;
  - no pad; done pulses once; s_tready low after the 8th handshake.
- word_num=6, data 0xA0..0xA5:
  - writes at addr 0..5;
  - then pad writes of 0 at addr 6,7;
  - done follows; total ram_we pulses = 8.
- word_num=0:
  - start -> done exactly 2 cycles later (IDLE->DONE->done pulse);
  - no ram_we; s_tready never high.
- word_num=5 with random s_tvalid gaps, plus start pulsed again mid-load:
  - exactly 5 data writes in order, then pad writes at addr 5..7;
  - second start ignored; with BIAS_LOAD_CHECKSUM_EN, checksum = XOR of the 5 words.
- word_num=12, rst asserted after 3 handshakes:
  - outputs go to reset values asynchronously;
  - a following start with word_num=4 writes addr 0..3 and pulses done normally.
- word_num=600:
  - clipped to 512; addresses 0..511, no pad;
  - s_tready drops after the 512th handshake.

Source files
------------

// File: rtl/bias_ram_loader_pkg.sv
// ---------------------------------------------------------------------------
// bias_ram_loader_pkg
// Shared constants and types for the bias RAM loader.
//   AXI_WIDTH_DATA  : width of one DMA stream word (and one bias RAM write word)
//   CHANNEL_OUT_NUM : output channels; each bias is 32 bits wide
//   WORDS_PER_ROW   : write words that make up one bias RAM read row
//   ROW_SEL_BITS    : low address bits selecting a word inside a read row
//   load_state_e    : loader FSM states
// ---------------------------------------------------------------------------
package bias_ram_loader_pkg;

  localparam int AXI_WIDTH_DATA  = 64;
  localparam int CHANNEL_OUT_NUM = 8;
  localparam int WORDS_PER_ROW   = (CHANNEL_OUT_NUM * 32) / AXI_WIDTH_DATA;
  localparam int ROW_SEL_BITS    = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } load_state_e;

endpackage

// File: rtl/bias_ram_loader.sv
// ---------------------------------------------------------------------------
// bias_ram_loader
// Turns a stream of packed bias words from the AXI DMA into bias RAM write
// port signals. Loads a programmed number of words from address 0, zero-pads
// the tail up to a full read row, then pulses done to the layer controller.
//
// Ports:
//   clk, rst   : single clock, asynchronous active-high reset
//   start      : one-cycle load request, only honoured while idle
//   word_num   : number of words to load (clipped to 2^ADDR_BITS)
//   s_tdata/s_tvalid/s_tready : incoming stream handshake
//   ram_wdata/ram_waddr/ram_we : bias RAM write port
//   busy       : high from accepted start until the done pulse
//   done       : one-cycle completion pulse
//   checksum   : XOR of all accepted words (only with BIAS_LOAD_CHECKSUM_EN)
//
// Optional feature macro: BIAS_LOAD_CHECKSUM_EN
// ---------------------------------------------------------------------------
module bias_ram_loader
  import bias_ram_loader_pkg::*;
#(
  parameter int ADDR_BITS = 9,
  parameter int DATA_W    = AXI_WIDTH_DATA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   word_num,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic                 ram_we,
  output logic                 busy,
`ifdef BIAS_LOAD_CHECKSUM_EN
  output logic                 done,
  output logic [DATA_W-1:0]    checksum
`else
  output logic                 done
`endif
);

  // Full RAM depth; the counters are one bit wider so this value fits.
  localparam logic [ADDR_BITS:0] MAX_WORDS = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ADDR_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};

  load_state_e            state_q, state_d;
  logic [ADDR_BITS:0]     n_q, n_d;
  logic [ADDR_BITS:0]     addr_q, addr_d;
  logic                   s_tready_q, s_tready_d;
  logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
  logic [ADDR_BITS-1:0]   ram_waddr_q, ram_waddr_d;
  logic                   ram_we_q, ram_we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   handshake;
  logic [ADDR_BITS:0]     addr_inc;
  logic                   last_word;
  logic [ADDR_BITS:0]     n_clip;

  // A word is taken only while we advertise ready; the address counter also
  // counts accepted words, so the N-th handshake is when addr+1 reaches N.
  assign handshake = s_tvalid & s_tready_q;
  assign addr_inc  = addr_q + ADDR_ONE;
  assign last_word = (addr_inc == n_q);
  assign n_clip    = (word_num > MAX_WORDS) ? MAX_WORDS : word_num;

  // Next-state and registered-output logic. Every output is registered, so
  // a write appears exactly one cycle after the handshake (or pad step) that
  // produced it, and ready drops the cycle after the final handshake.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    addr_d      = addr_q;
    s_tready_d  = s_tready_q;
    ram_wdata_d = ram_wdata_q;
    ram_waddr_d = ram_waddr_q;
    ram_we_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = n_clip;
          addr_d = '0;
          busy_d = 1'b1;
          if (n_clip == '0) begin
            state_d = DONE;
          end else begin
            state_d    = LOAD;
            s_tready_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (handshake) begin
          ram_we_d    = 1'b1;
          ram_wdata_d = s_tdata;
          ram_waddr_d = addr_q[ADDR_BITS-1:0];
          addr_d      = addr_inc;
          if (last_word) begin
            s_tready_d = 1'b0;
            // A full RAM (N = 2^ADDR_BITS) is row aligned, so it skips PAD.
            state_d    = (n_q[ROW_SEL_BITS-1:0] != '0) ? PAD : DONE;
          end
        end
      end

      PAD: begin
        ram_we_d    = 1'b1;
        ram_wdata_d = '0;
        ram_waddr_d = addr_q[ADDR_BITS-1:0];
        addr_d      = addr_inc;
        if (addr_inc[ROW_SEL_BITS-1:0] == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle at once,
  // abandoning any partially loaded RAM contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      s_tready_q  <= 1'b0;
      ram_wdata_q <= '0;
      ram_waddr_q <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      s_tready_q  <= s_tready_d;
      ram_wdata_q <= ram_wdata_d;
      ram_waddr_q <= ram_waddr_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_tready  = s_tready_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef BIAS_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running XOR of accepted words. Pad words are zero and would not change
  // it, so only handshakes are folded in. It stays put after done until the
  // next accepted start clears it.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start) begin
      checksum_d = '0;
    end else if (state_q == LOAD && handshake) begin
      checksum_d = checksum_q ^ s_tdata;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bias_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_bias_ram_loader
// Directed bench for bias_ram_loader. The stimulus task pushes every expected
// RAM write (address, data, cycle it must appear in) into a queue as it is
// caused; a separate monitor pops and compares whenever ram_we is seen.
// ---------------------------------------------------------------------------
module tb_bias_ram_loader;
  import bias_ram_loader_pkg::*;

  localparam int ADDR_BITS = 9;
  localparam int DATA_W    = 64;
  localparam int RAM_WORDS = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [ADDR_BITS:0]   wordNum;
  logic [DATA_W-1:0]    sTdata;
  logic                 sTvalid;
  logic                 sTready;
  logic [DATA_W-1:0]    ramWdata;
  logic [ADDR_BITS-1:0] ramWaddr;
  logic                 ramWe;
  logic                 busy;
  logic                 done;
`ifdef BIAS_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]    checksum;
`endif

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    data;
    int                   due;
  } write_t;

  write_t            expQ[$];
  write_t            expEntry;
  int                checks     = 0;
  int                failures   = 0;
  int                cycleCount = 0;
  int                weCount    = 0;
  int                readyCount = 0;
  logic [DATA_W-1:0] xorExp;
  int                latency;

  bias_ram_loader #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .word_num (wordNum),
    .s_tdata  (sTdata),
    .s_tvalid (sTvalid),
    .s_tready (sTready),
    .ram_wdata(ramWdata),
    .ram_waddr(ramWaddr),
    .ram_we   (ramWe),
    .busy     (busy),
`ifdef BIAS_LOAD_CHECKSUM_EN
    .done     (done),
    .checksum (checksum)
`else
    .done     (done)
`endif
  );

  // Free-running clock and a cycle counter used to time-stamp writes.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compare one value and report a failure line if it differs.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write, including
  // the exact cycle in which it was due.
  always @(negedge clk) begin
    if (sTready) readyCount++;
    if (ramWe) begin
      weCount++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%0h required=none", ramWaddr, ramWdata);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("write_addr", 64'(ramWaddr), 64'(expEntry.addr));
        checkOutput("write_data", ramWdata, expEntry.data);
        checkOutput("write_cycle", 64'(cycleCount), 64'(expEntry.due));
      end
    end
  end

  // Run one load: pulse start, feed feedCount words (optionally with random
  // valid gaps and a stray start mid-load), push the expected writes and pads,
  // then wait for done unless the load was deliberately cut short.
  task automatic applyStimulus(input int reqWords, input logic [63:0] base,
                               input bit gaps, input int restartAt,
                               input int feedCount, output int doneLatency);
    int n, idx, guard, lastHs, startCycle, padAddr, padK;
    bit hs, restarted, gotDone;
    n           = (reqWords > RAM_WORDS) ? RAM_WORDS : reqWords;
    xorExp      = '0;
    weCount     = 0;
    readyCount  = 0;
    doneLatency = -1;
    restarted   = 1'b0;
    wordNum     = reqWords[ADDR_BITS:0];
    start       = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    startCycle = cycleCount;
    checkOutput("busy_after_start", 64'(busy), 64'd1);

    idx    = 0;
    guard  = 0;
    lastHs = cycleCount;
    while (idx < feedCount && guard < 4000) begin
      sTvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      sTdata  = base + 64'(idx);
      if (!restarted && restartAt >= 0 && idx == restartAt) begin
        start     = 1'b1;
        wordNum   = 10'd3;
        restarted = 1'b1;
      end
      @(negedge clk);
      hs = sTvalid && sTready;
      if (hs) begin
        expQ.push_back('{addr: idx[ADDR_BITS-1:0], data: base + 64'(idx), due: cycleCount + 1});
        xorExp = xorExp ^ (base + 64'(idx));
        lastHs = cycleCount;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      guard++;
    end
    if (guard >= 4000) begin
      checkOutput("feed_timeout", 64'(idx), 64'(feedCount));
    end
    if (feedCount < n) begin
      sTvalid = 1'b0;
      return;
    end

    if (n > 0) begin
      checkOutput("ready_drop", 64'(sTready), 64'd0);
    end
    padAddr = n;
    padK    = 0;
    while (n > 0 && (padAddr % WORDS_PER_ROW) != 0) begin
      expQ.push_back('{addr: padAddr[ADDR_BITS-1:0], data: '0, due: lastHs + 2 + padK});
      padAddr++;
      padK++;
    end

    sTvalid = 1'b1;
    sTdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    guard   = 0;
    gotDone = 1'b0;
    while (!gotDone && guard < 100) begin
      @(negedge clk);
      gotDone = done;
      guard++;
    end
    checkOutput("done_seen", 64'(gotDone), 64'd1);
    doneLatency = cycleCount - startCycle + 1;
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    checkOutput("we_at_done", 64'(ramWe), 64'd0);
`ifdef BIAS_LOAD_CHECKSUM_EN
    checkOutput("checksum", checksum, xorExp);
`endif
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(done), 64'd0);
    sTvalid = 1'b0;
    checkOutput("writes_pending", 64'(expQ.size()), 64'd0);
    checkOutput("write_count", 64'(weCount), 64'(((n + 3) / 4) * 4));
  endtask

  // Watchdog so the run always ends even if the DUT stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    wordNum = '0;
    sTdata  = '0;
    sTvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tready", 64'(sTready), 64'd0);
    checkOutput("reset_we", 64'(ramWe), 64'd0);
    checkOutput("reset_waddr", 64'(ramWaddr), 64'd0);
    checkOutput("reset_wdata", ramWdata, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] load of 8 words, valid held high");
    applyStimulus(8, 64'h1, 1'b0, -1, 8, latency);

    $display("[TB] load of 6 words, two pad writes expected");
    applyStimulus(6, 64'hA0, 1'b0, -1, 6, latency);

    $display("[TB] empty load");
    applyStimulus(0, 64'h0, 1'b0, -1, 0, latency);
    checkOutput("zero_done_latency", 64'(latency), 64'd2);
    checkOutput("zero_ready_never", 64'(readyCount), 64'd0);

    $display("[TB] load of 5 words with valid gaps and a stray start");
    applyStimulus(5, 64'h5A5A_0000_0000_0011, 1'b1, 2, 5, latency);

    $display("[TB] reset in the middle of a 12 word load");
    applyStimulus(12, 64'hC0, 1'b0, -1, 3, latency);
    @(negedge clk);
    #2;
    rst     = 1'b1;
    sTvalid = 1'b1;
    sTdata  = 64'hBAD0;
    #1;
    checkOutput("midreset_tready", 64'(sTready), 64'd0);
    checkOutput("midreset_we", 64'(ramWe), 64'd0);
    checkOutput("midreset_waddr", 64'(ramWaddr), 64'd0);
    checkOutput("midreset_wdata", ramWdata, 64'd0);
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_hold_tready", 64'(sTready), 64'd0);
    rst     = 1'b0;
    sTvalid = 1'b0;
    @(negedge clk);
    applyStimulus(4, 64'hD0, 1'b0, -1, 4, latency);

    $display("[TB] oversize request clipped to the full RAM");
    applyStimulus(600, 64'h1000, 1'b0, -1, RAM_WORDS, latency);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
